// File: rtl/hilo_muldiv_ctrl_if.sv
// Execute-stage <-> HI/LO controller bundle: request, MFHI/MFLO read strobe, flush and results.
interface hilo_muldiv_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        rd_valid;
  logic        stall;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  modport master (
    output req_valid, req_op, req_a, req_b, rd_valid, flush,
    input  req_ready, stall, hi, lo, done
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rd_valid, flush,
    output req_ready, stall, hi, lo, done
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner: multi-cycle multiply, 32-step restoring divide, MTHI/MTLO, flush abort.
// Optional macro HILO_FWD_EN: hi/lo bypass the value being written at the coming edge.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input logic              clk,
  input logic              resetn,
  hilo_muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic        sgn_q, sgn_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        hi_we, lo_we, last_we;

  logic [63:0] mul_a_ext, mul_b_ext, product;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] step_rem, step_quo, q_fix, r_fix;
  logic        neg_a, neg_b;

  // Datapath shared by the last multiply cycle and every divide iteration.
  always_comb begin
    mul_a_ext = sgn_q ? {{32{opa_q[31]}}, opa_q} : {32'b0, opa_q};
    mul_b_ext = sgn_q ? {{32{opb_q[31]}}, opb_q} : {32'b0, opb_q};
    product   = mul_a_ext * mul_b_ext;

    rem_shift = {rem_q, quo_q[31]};
    rem_ge    = rem_shift >= {1'b0, dvs_q};
    step_rem  = rem_ge ? 32'(rem_shift - {1'b0, dvs_q}) : rem_shift[31:0];
    step_quo  = {quo_q[30:0], rem_ge};

    neg_a = sgn_q & opa_q[31];
    neg_b = sgn_q & opb_q[31];
    q_fix = (neg_a ^ neg_b) ? -step_quo : step_quo;
    r_fix = neg_a ? -step_rem : step_rem;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    last_we = 1'b0;

    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            opa_d = bus.req_a;
            opb_d = bus.req_b;
            sgn_d = (bus.req_op == OP_MULT) || (bus.req_op == OP_DIV);
            cnt_d = '0;
            unique case (bus.req_op)
              OP_MULT, OP_MULTU: state_d = S_MUL;
              OP_DIV, OP_DIVU: begin
                state_d = S_DIV;
                rem_d   = '0;
                quo_d   = (sgn_d && bus.req_a[31]) ? -bus.req_a : bus.req_a;
                dvs_d   = (sgn_d && bus.req_b[31]) ? -bus.req_b : bus.req_b;
              end
              OP_MTHI: begin
                hi_d  = bus.req_a;
                hi_we = 1'b1;
              end
              OP_MTLO: begin
                lo_d  = bus.req_a;
                lo_we = 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt_q == MUL_LAST) begin
            {hi_d, lo_d} = product;
            hi_we   = 1'b1;
            lo_we   = 1'b1;
            last_we = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_DIV: begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == DIV_LAST) begin
            // A zero divisor returns the dividend untouched and an all-ones quotient.
            if (opb_q == 32'd0) begin
              hi_d = opa_q;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = r_fix;
              lo_d = q_fix;
            end
            hi_we   = 1'b1;
            lo_we   = 1'b1;
            last_we = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: all flops, operands included, take the synchronous reset so nothing powers up X.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
      done_q  <= last_we;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.done      = done_q;

`ifdef HILO_FWD_EN
  assign bus.hi    = hi_we ? hi_d : hi_q;
  assign bus.lo    = lo_we ? lo_d : lo_q;
  assign bus.stall = (bus.req_valid | bus.rd_valid) & ~bus.req_ready & ~last_we;
`else
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = (bus.req_valid | bus.rd_valid) & ~bus.req_ready;
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench: cycle-level behavioural model of HI/LO plus directed literal checks and random traffic.
module tb_hilo_muldiv_ctrl;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_ctrl_if bus();

  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: architectural HI/LO, a busy countdown, and the result pending for the final edge.
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic        m_done = 1'b0;
  int          m_busy = 0;

  logic [31:0] s_hi, s_lo;
  logic        s_done, s_stall, s_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Returns {hi, lo} = {remainder, quotient}.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  task automatic model_update(input logic v, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic fl, input logic rn);
    if (!rn) begin
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_busy = 0;
    end else begin
      m_done = 1'b0;
      if (fl) begin
        m_busy = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_hi = m_phi; m_lo = m_plo; m_done = 1'b1;
        end
      end else if (v) begin
        case (op)
          3'd0, 3'd1: begin m_busy = MUL_LAT; {m_phi, m_plo} = ref_mul(op == 3'd0, a, b); end
          3'd2, 3'd3: begin m_busy = 32;      {m_phi, m_plo} = ref_div(op == 3'd2, a, b); end
          3'd4: m_hi = a;
          3'd5: m_lo = a;
          default: ;
        endcase
      end
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs to the model, then advance the model.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rv, input logic fl, input logic rn);
    logic        e_ready, e_stall;
    logic [31:0] e_hi, e_lo;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rd_valid  = rv;
    bus.flush     = fl;
    resetn        = rn;
    #1;
    e_ready = (m_busy == 0);
    e_stall = (v | rv) & ~e_ready;
    e_hi    = m_hi;
    e_lo    = m_lo;
`ifdef HILO_FWD_EN
    if (m_busy == 1 && !fl) begin
      e_stall = 1'b0; e_hi = m_phi; e_lo = m_plo;
    end
    if (e_ready && v && !fl && op == 3'd4) e_hi = a;
    if (e_ready && v && !fl && op == 3'd5) e_lo = a;
`endif
    s_hi = bus.hi; s_lo = bus.lo; s_done = bus.done; s_stall = bus.stall; s_ready = bus.req_ready;
    check("ready", 64'(s_ready), 64'(e_ready));
    check("stall", 64'(s_stall), 64'(e_stall));
    check("hi",    64'(s_hi),    64'(e_hi));
    check("lo",    64'(s_lo),    64'(e_lo));
    check("done",  64'(s_done),  64'(m_done));
    @(posedge clk);
    model_update(v, op, a, b, fl, rn);
  endtask

  task automatic idle(input logic rv);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, rv, 1'b0, 1'b1);
  endtask

  // Issues one op and runs until done is seen (bounded); lat counts cycles after acceptance.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rv, output int lat, output int stalls);
    cycle(1'b1, op, a, b, rv, 1'b0, 1'b1);
    lat = 0;
    stalls = 0;
    do begin
      idle(rv);
      lat++;
      if (s_stall) stalls++;
    end while (!s_done && lat < 40);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic        r_v, r_rv, r_fl, r_rn;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;

  initial begin
    int lat, stalls, dones;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_a = '0; bus.req_b = '0;
    bus.rd_valid = 1'b0;  bus.flush = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);

    // Reset after HI/LO were loaded.
    cycle(1'b1, 3'd4, 32'hAAAA_1111, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 3'd5, 32'h5555_2222, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("preload_hi", 64'(s_hi), 64'h0000_0000_AAAA_1111);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    check("rst_hi",    64'(s_hi),    64'd0);
    check("rst_lo",    64'(s_lo),    64'd0);
    check("rst_ready", 64'(s_ready), 64'd1);
    check("rst_done",  64'(s_done),  64'd0);
    check("rst_stall", 64'(s_stall), 64'd0);

    // Multiplies.
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, lat, stalls);
    check("mult_lat", 64'(lat), 64'(MUL_LAT + 1));
    check("mult_hi",  64'(s_hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo",  64'(s_lo), 64'h0000_0000_FFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, lat, stalls);
    check("multu_lat", 64'(lat), 64'(MUL_LAT + 1));
    check("multu_hi",  64'(s_hi), 64'h0000_0000_0000_0001);
    check("multu_lo",  64'(s_lo), 64'h0000_0000_FFFF_FFFE);

    // Divides.
    run_op(3'd3, 32'd100, 32'd7, 1'b0, lat, stalls);
    check("divu_lat", 64'(lat), 64'd33);
    check("divu_lo",  64'(s_lo), 64'd14);
    check("divu_hi",  64'(s_hi), 64'd2);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, stalls);
    check("div_neg_lo", 64'(s_lo), 64'h0000_0000_FFFF_FFFD);
    check("div_neg_hi", 64'(s_hi), 64'h0000_0000_FFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, stalls);
    check("div_ovf_lo", 64'(s_lo), 64'h0000_0000_8000_0000);
    check("div_ovf_hi", 64'(s_hi), 64'd0);

    // Divide by zero with MFHI/MFLO waiting the whole time.
    run_op(3'd3, 32'd5, 32'd0, 1'b1, lat, stalls);
    check("div0_lat",   64'(lat), 64'd33);
    check("div0_hi",    64'(s_hi), 64'd5);
    check("div0_lo",    64'(s_lo), 64'h0000_0000_FFFF_FFFF);
    check("div0_stall_end", 64'(s_stall), 64'd0);
`ifdef HILO_FWD_EN
    check("div0_stalls", 64'(stalls), 64'd31);
`else
    check("div0_stalls", 64'(stalls), 64'd32);
`endif

    // Flush at iteration 10, then on the final cycle, then on an MTHI acceptance.
    cycle(1'b1, 3'd2, 32'd100, 32'd3, 1'b0, 1'b0, 1'b1);
    repeat (9) idle(1'b0);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    dones = 0;
    idle(1'b0);
    check("fl10_ready", 64'(s_ready), 64'd1);
    repeat (40) begin idle(1'b0); if (s_done) dones++; end
    check("fl10_nodone", 64'(dones), 64'd0);
    check("fl10_hi", 64'(s_hi), 64'd5);
    check("fl10_lo", 64'(s_lo), 64'h0000_0000_FFFF_FFFF);

    cycle(1'b1, 3'd2, 32'd100, 32'd3, 1'b0, 1'b0, 1'b1);
    repeat (31) idle(1'b0);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    dones = 0;
    repeat (5) begin idle(1'b0); if (s_done) dones++; end
    check("flfin_nodone", 64'(dones), 64'd0);
    check("flfin_hi", 64'(s_hi), 64'd5);
    check("flfin_lo", 64'(s_lo), 64'h0000_0000_FFFF_FFFF);

    cycle(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b0);
    check("flmthi_hi", 64'(s_hi), 64'd5);

    // Back-to-back MTHI / MTLO.
    cycle(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b1);
`ifdef HILO_FWD_EN
    check("mthi_fwd", 64'(s_hi), 64'h0000_0000_1234_5678);
`endif
    cycle(1'b1, 3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("mthi_hi",    64'(s_hi),    64'h0000_0000_1234_5678);
    check("mthi_stall", 64'(s_stall), 64'd0);
    idle(1'b0);
    check("mtlo_lo", 64'(s_lo), 64'h0000_0000_9ABC_DEF0);
    check("mtlo_hi", 64'(s_hi), 64'h0000_0000_1234_5678);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      r_v  = ($urandom_range(0, 1) == 0);
      r_op = 3'($urandom_range(0, 7));
      r_a  = pick();
      r_b  = pick();
      r_rv = ($urandom_range(0, 3) == 0);
      r_fl = ($urandom_range(0, 99) < 2);
      r_rn = ($urandom_range(0, 299) != 0);
      cycle(r_v, r_op, r_a, r_b, r_rv, r_fl, r_rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Owns the architectural HI/LO register pair and sequences every write to it.
- MULT/MULTU run as a fixed-latency pipelined multiply.
- DIV/DIVU run as a 32-iteration restoring divider.
- MTHI/MTLO are single-cycle writes.
It sits beside the execute stage, issues stall while busy, and aborts in-flight work on pipeline flush (exception/eret).

Parameters:
MUL_LAT, 2, cycles from multiply acceptance to HI/LO update; legal range 1..4.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
req_valid  in  1  execute stage presents a HI/LO-writing op
req_op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (treated as no-op)
req_a  in  32  rs value (dividend / multiplicand / MTHI-MTLO source)
req_b  in  32  rt value (divisor / multiplier)
req_ready  out  1  high when state==IDLE
rd_valid  in  1  execute stage is executing MFHI/MFLO this cycle
stall  out  1  (req_valid|rd_valid) & ~req_ready
flush  in  1  abandon in-flight op
hi  out  32  HI register
lo  out  32  LO register
done  out  1  one-cycle pulse: mul/div result now visible on hi/lo

Behaviour:
- Reset (resetn=0 at posedge): hi=lo=0, state=IDLE, counter=0, done=0. Reset mid-operation discards the op with no HI/LO write.
- Accept: req_valid & req_ready at posedge ending cycle T; operands are latched.
- States:
  - IDLE -> MUL (op 0/1), DIV (op 2/3), or stays IDLE (op 4/5/6/7).
  - MUL -> IDLE after MUL_LAT cycles.
  - DIV -> IDLE after 32 cycles.
- MTHI/MTLO:
  - hi (resp. lo) = req_a at the accepting edge; visible in T+1.
  - The other register is unchanged. No done pulse. req_ready stays 1.
- MULT/MULTU:
  - 64-bit product; signed for MULT, zero-extended for MULTU.
  - {hi,lo}=product written at the edge ending T+MUL_LAT; visible and done=1 in T+MUL_LAT+1.
- DIV/DIVU:
  - Operate on magnitudes (DIV) or raw values (DIVU); one quotient bit per cycle in cycles T+1..T+32.
  - Sign fixup is combinational at the final edge: quotient negated iff sign(a)^sign(b); remainder takes sign(a).
  - lo=quotient, hi=remainder written at the edge ending T+32; done=1 in T+33.
  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0.
  - Divisor 0 (both forms): still 32 cycles; hi=req_a, lo=0xFFFFFFFF; no hang.
- Busy (state!=IDLE):
  - req_ready=0.
  - Any req_valid or rd_valid raises stall. MFHI/MFLO therefore never reads a stale or partial value.
- flush:
  - At a posedge, state->IDLE and counter cleared; HI/LO unchanged; done=0 next cycle.
  - Flush wins over a same-cycle acceptance (request dropped, including MTHI/MTLO).
  - Flush wins over a same-cycle final write (no write).
- Back-to-back: a new request may be accepted in the same cycle done=1, since state is IDLE.
- req_op 6/7 accepted as no-op; no state change.

Optional Feature:
HILO_FWD_EN
- Defined: hi/lo outputs are combinational bypasses of the value being written at the coming edge (MTHI/MTLO acceptance, or final mul/div cycle). The MTHI/MTLO value is seen in cycle T. The mul/div result is seen one cycle early, in T+MUL_LAT or T+32. stall is deasserted in that final cycle.
- Undefined: hi/lo are pure register outputs, with timing as in Behaviour.

Test Plan:
1. Reset: hold resetn=0 for 2 cycles after hi/lo were loaded -> hi=lo=0, req_ready=1, done=0, stall=0.
2. MULT a=0xFFFFFFFF b=2 -> hi=0xFFFFFFFF lo=0xFFFFFFFE with done after MUL_LAT+1 cycles. MULTU with same operands -> hi=0x00000001 lo=0xFFFFFFFE.
3. DIVU 100/7 -> lo=14 hi=2 with done in T+33. DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
4. DIVU 5/0 -> 32 cycles, then hi=5 lo=0xFFFFFFFF. rd_valid held high during the divide -> stall=1 every busy cycle, 0 in T+33.
5. DIV started, flush at iteration 10 -> IDLE next cycle, hi/lo keep prior values, no done. Repeat with flush in the final cycle -> no write. Repeat with flush on an MTHI accept -> hi unchanged.
6. MTHI 0x12345678 then MTLO 0x9ABCDEF0 in consecutive cycles -> hi then lo updated one cycle after each; no stall.
   With HILO_FWD_EN -> hi shows 0x12345678 in the accept cycle itself.
